// File: rtl/mem_access_arbiter_pkg.sv
// mem_access_arbiter_pkg
//   Shared types and constants for the memory access arbiter.
//   - CUtoME_IF / MEtoCU_IF : core-to-memory request and memory-to-core response
//   - ArbStateType          : arbiter FSM states
//   - ArbOwnerType          : which requester owns the current transaction
//   - DEFAULT_TIMEOUT_CYCLES, DEFAULT_ERR_DATA : parameter defaults
//   - wd_width()            : watchdog counter width (never zero)
package mem_access_arbiter_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;
    localparam logic [31:0] DEFAULT_ERR_DATA       = 32'hDEAD_BEEF;

    // me_x is encoded as zero so a reset request register reads as "no operation".
    typedef enum logic [1:0] {
        me_x  = 2'd0,
        me_rd = 2'd1,
        me_wr = 2'd2
    } MemFuncType;

    typedef enum logic [2:0] {
        mt_x  = 3'd0,
        mt_b  = 3'd1,
        mt_h  = 3'd2,
        mt_w  = 3'd3,
        mt_bu = 3'd4,
        mt_hu = 3'd5
    } MemMaskType;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        MemFuncType  req;
        MemMaskType  mask;
    } CUtoME_IF;

    typedef struct packed {
        logic [31:0] loadeddata;
    } MEtoCU_IF;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } ArbStateType;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } ArbOwnerType;

    // Counter width able to hold TIMEOUT_CYCLES; a disabled watchdog still
    // gets a 1-bit counter so no zero-width vectors appear.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_access_arbiter_watchdog.sv
// mem_arb_watchdog
//   Counts the cycles a memory request has been outstanding and flags expiry.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     clear     : pulse in the cycle the memory accepts the request
//     enable    : high while waiting for the memory response
//     expired   : asserted (only while enabled) in the last waiting cycle, so
//                 the forced response lands TIMEOUT_CYCLES cycles after the
//                 memory accepted the request
//   TIMEOUT_CYCLES = 0 disables the watchdog (expired stays low).
module mem_arb_watchdog
    import mem_access_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CNT_W = wd_width(TIMEOUT_CYCLES);
    localparam bit              WD_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] FIRE = WD_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The counter holds "cycles elapsed since the memory accepted": the accept
    // cycle itself counts as the first, hence the load of 1 on clear.
    // It saturates at TIMEOUT_CYCLES and never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_W'(1);
        end else if (enable && (count_q != SAT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = WD_ON && enable && (count_q >= FIRE);

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares one memory port between instruction fetch (if_*) and data
//   load/store (dm_*). Round-robin grant, one outstanding transaction.
//   Ports:
//     clk, rst                       : clock, synchronous active-high reset
//     if_req_valid/ready, if_req     : fetch request handshake
//     if_resp_valid, if_resp, if_resp_err : one-cycle fetch response
//     dm_req_valid/ready, dm_req     : data request handshake
//     dm_resp_valid, dm_resp, dm_resp_err : one-cycle data response
//     me_req_valid/ready, me_req     : request to memory
//     me_resp_valid, me_resp         : response pulse from memory
//     dbg_state                      : current FSM state
//   Handshake: a request transfers on the rising edge where valid && ready are
//   both high; a source holds valid and payload stable until that edge, and
//   ready never depends on anything but valid and internal state.
//   FSM: ARB_IDLE -> ARB_ISSUE -> ARB_WAIT -> ARB_RESP -> ARB_IDLE, with
//   ARB_IDLE -> ARB_RESP directly for an me_x request (error, memory skipped).
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  CUtoME_IF    if_req,
    output logic        if_resp_valid,
    output MEtoCU_IF    if_resp,
    output logic        if_resp_err,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    input  CUtoME_IF    dm_req,
    output logic        dm_resp_valid,
    output MEtoCU_IF    dm_resp,
    output logic        dm_resp_err,
    output logic        me_req_valid,
    input  logic        me_req_ready,
    output CUtoME_IF    me_req,
    input  logic        me_resp_valid,
    input  MEtoCU_IF    me_resp,
    output ArbStateType dbg_state
);

    ArbStateType state_q, state_d;
    ArbOwnerType last_grant_q, last_grant_d;
    ArbOwnerType owner_q, owner_d;
    logic        err_q, err_d;
    CUtoME_IF    req_q, req_d;
    MEtoCU_IF    resp_q, resp_d;

    logic        grant_if;
    logic        grant_dm;
    CUtoME_IF    sel_req;
    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;

    // With both requesters valid, the one that did not win last time wins now.
    assign grant_if = if_req_valid && (!dm_req_valid || (last_grant_q == GNT_DM));
    assign grant_dm = dm_req_valid && (!if_req_valid || (last_grant_q == GNT_IF));

    assign wd_clear  = (state_q == ARB_ISSUE) && me_req_ready;
    assign wd_enable = (state_q == ARB_WAIT);

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register (FSM plus the transaction registers it owns).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_DM;
            owner_q      <= GNT_IF;
            err_q        <= 1'b0;
            req_q        <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        err_d        = err_q;
        req_d        = req_q;
        resp_d       = resp_q;
        sel_req      = grant_if ? if_req : dm_req;

        case (state_q)
            ARB_IDLE: begin
                if (grant_if || grant_dm) begin
                    owner_d      = grant_if ? GNT_IF : GNT_DM;
                    last_grant_d = grant_if ? GNT_IF : GNT_DM;
                    req_d        = sel_req;
                    if (sel_req.req == me_x) begin
                        state_d           = ARB_RESP;
                        err_d             = 1'b1;
                        resp_d.loadeddata = ERR_DATA;
                    end else begin
                        state_d = ARB_ISSUE;
                        err_d   = 1'b0;
                    end
                end
            end
            ARB_ISSUE: begin
                if (me_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // A real response wins over a watchdog expiry in the same cycle.
                if (me_resp_valid) begin
                    state_d = ARB_RESP;
                    err_d   = 1'b0;
                    resp_d  = me_resp;
                end else if (wd_expired) begin
                    state_d           = ARB_RESP;
                    err_d             = 1'b1;
                    resp_d.loadeddata = ERR_DATA;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        if_req_ready  = (state_q == ARB_IDLE) && grant_if;
        dm_req_ready  = (state_q == ARB_IDLE) && grant_dm;
        me_req_valid  = (state_q == ARB_ISSUE);
        me_req        = req_q;
        if_resp_valid = (state_q == ARB_RESP) && (owner_q == GNT_IF);
        dm_resp_valid = (state_q == ARB_RESP) && (owner_q == GNT_DM);
        if_resp_err   = if_resp_valid && err_q;
        dm_resp_err   = dm_resp_valid && err_q;
        if_resp       = resp_q;
        dm_resp       = resp_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  CUtoME_IF    if_req;
  logic        if_resp_valid;
  MEtoCU_IF    if_resp;
  logic        if_resp_err;
  logic        dm_req_valid;
  logic        dm_req_ready;
  CUtoME_IF    dm_req;
  logic        dm_resp_valid;
  MEtoCU_IF    dm_resp;
  logic        dm_resp_err;
  logic        me_req_valid;
  logic        me_req_ready;
  CUtoME_IF    me_req;
  logic        me_resp_valid;
  MEtoCU_IF    me_resp;
  ArbStateType dbg_state;

  int n_checks;
  int n_fail;

  mem_access_arbiter #(
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req        (if_req),
    .if_resp_valid (if_resp_valid),
    .if_resp       (if_resp),
    .if_resp_err   (if_resp_err),
    .dm_req_valid  (dm_req_valid),
    .dm_req_ready  (dm_req_ready),
    .dm_req        (dm_req),
    .dm_resp_valid (dm_resp_valid),
    .dm_resp       (dm_resp),
    .dm_resp_err   (dm_resp_err),
    .me_req_valid  (me_req_valid),
    .me_req_ready  (me_req_ready),
    .me_req        (me_req),
    .me_resp_valid (me_resp_valid),
    .me_resp       (me_resp),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=no_finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  // check helpers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input CUtoME_IF obs, input CUtoME_IF exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input ArbStateType exp);
    chk32(tag, {30'd0, dbg_state}, {30'd0, exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_if_ready"}, if_req_ready, 1'b0);
    chk1({tag, "_dm_ready"}, dm_req_ready, 1'b0);
    chk1({tag, "_me_valid"}, me_req_valid, 1'b0);
    chk_req({tag, "_me_req"}, me_req, '0);
    chk1({tag, "_if_rvalid"}, if_resp_valid, 1'b0);
    chk1({tag, "_dm_rvalid"}, dm_resp_valid, 1'b0);
    chk1({tag, "_if_err"}, if_resp_err, 1'b0);
    chk1({tag, "_dm_err"}, dm_resp_err, 1'b0);
    chk32({tag, "_if_data"}, if_resp.loadeddata, 32'h0);
    chk32({tag, "_dm_data"}, dm_resp.loadeddata, 32'h0);
    chk_state({tag, "_state"}, ARB_IDLE);
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic CUtoME_IF mk_req(input logic [31:0] addr, input logic [31:0] data,
                                      input MemFuncType f, input MemMaskType m);
    CUtoME_IF r;
    r.addr = addr;
    r.data = data;
    r.req  = f;
    r.mask = m;
    return r;
  endfunction

  CUtoME_IF exp_req;
  logic     exp_if;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    if_req_valid  = 1'b0;
    if_req        = '0;
    dm_req_valid  = 1'b0;
    dm_req        = '0;
    me_req_ready  = 1'b0;
    me_resp_valid = 1'b0;
    me_resp       = '0;

    // reset state
    tick();
    tick();
    chk_reset_outputs("reset");

    // fetch only: accept at A, issue A+1, memory answers A+2, response A+3
    rst          = 1'b0;
    exp_req      = mk_req(32'h100, 32'h0, me_rd, mt_w);
    if_req       = exp_req;
    if_req_valid = 1'b1;
    me_req_ready = 1'b1;
    settle();
    chk1("fetch_if_ready", if_req_ready, 1'b1);
    chk1("fetch_dm_ready", dm_req_ready, 1'b0);
    tick();
    if_req_valid = 1'b0;
    settle();
    chk_state("fetch_issue_state", ARB_ISSUE);
    chk1("fetch_me_valid", me_req_valid, 1'b1);
    chk_req("fetch_me_req", me_req, exp_req);
    tick();
    me_resp_valid      = 1'b1;
    me_resp.loadeddata = 32'h0000_0013;
    settle();
    chk_state("fetch_wait_state", ARB_WAIT);
    chk1("fetch_me_valid_wait", me_req_valid, 1'b0);
    chk1("fetch_no_early_resp", if_resp_valid, 1'b0);
    tick();
    me_resp_valid = 1'b0;
    me_resp       = '0;
    settle();
    chk1("fetch_resp_valid", if_resp_valid, 1'b1);
    chk32("fetch_resp_data", if_resp.loadeddata, 32'h0000_0013);
    chk1("fetch_resp_err", if_resp_err, 1'b0);
    chk1("fetch_dm_quiet", dm_resp_valid, 1'b0);
    tick();
    settle();
    chk1("fetch_resp_one_cycle", if_resp_valid, 1'b0);
    chk_state("fetch_back_idle", ARB_IDLE);

    // both valid every cycle from reset: IF,DM,IF,DM,IF,DM
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    if_req       = mk_req(32'h400, 32'h0, me_rd, mt_w);
    dm_req       = mk_req(32'h800, 32'h0, me_rd, mt_w);
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    me_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_if = ((i % 2) == 0);
      settle();
      chk1($sformatf("rr%0d_if_ready", i), if_req_ready, exp_if);
      chk1($sformatf("rr%0d_dm_ready", i), dm_req_ready, !exp_if);
      tick();
      settle();
      chk32($sformatf("rr%0d_me_addr", i), me_req.addr, exp_if ? 32'h400 : 32'h800);
      chk1($sformatf("rr%0d_no_ready_busy", i), if_req_ready | dm_req_ready, 1'b0);
      tick();
      me_resp_valid      = 1'b1;
      me_resp.loadeddata = 32'h1000 + 32'(i);
      tick();
      me_resp_valid = 1'b0;
      settle();
      chk1($sformatf("rr%0d_if_rvalid", i), if_resp_valid, exp_if);
      chk1($sformatf("rr%0d_dm_rvalid", i), dm_resp_valid, !exp_if);
      chk32($sformatf("rr%0d_data", i), exp_if ? if_resp.loadeddata : dm_resp.loadeddata,
            32'h1000 + 32'(i));
      tick();
    end
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;

    // data store with memory backpressure for one cycle
    exp_req      = mk_req(32'h2000, 32'hCAFE_F00D, me_wr, mt_w);
    dm_req       = exp_req;
    dm_req_valid = 1'b1;
    me_req_ready = 1'b0;
    settle();
    chk1("st_dm_ready", dm_req_ready, 1'b1);
    tick();
    dm_req_valid = 1'b0;
    dm_req       = '0;
    settle();
    chk1("st_me_valid", me_req_valid, 1'b1);
    chk_req("st_me_req", me_req, exp_req);
    tick();
    me_req_ready = 1'b1;
    settle();
    chk1("st_me_valid_held", me_req_valid, 1'b1);
    chk_req("st_me_req_stable", me_req, exp_req);
    tick();
    me_resp_valid = 1'b1;
    me_resp       = '0;
    tick();
    me_resp_valid = 1'b0;
    settle();
    chk1("st_dm_rvalid", dm_resp_valid, 1'b1);
    chk1("st_dm_err", dm_resp_err, 1'b0);
    chk1("st_if_quiet", if_resp_valid, 1'b0);
    tick();
    settle();
    chk1("st_dm_rvalid_drop", dm_resp_valid, 1'b0);

    // memory never answers: error response 8 cycles after memory accept
    dm_req       = mk_req(32'h3000, 32'h0, me_rd, mt_w);
    dm_req_valid = 1'b1;
    settle();
    chk1("to_dm_ready", dm_req_ready, 1'b1);
    tick();
    dm_req_valid = 1'b0;
    settle();
    chk1("to_me_valid", me_req_valid, 1'b1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      settle();
      chk1($sformatf("to_wait%0d_quiet", k), dm_resp_valid, 1'b0);
      chk_state($sformatf("to_wait%0d_state", k), ARB_WAIT);
    end
    tick();
    me_resp_valid      = 1'b1;
    me_resp.loadeddata = 32'h1234_5678;
    settle();
    chk1("to_dm_rvalid", dm_resp_valid, 1'b1);
    chk1("to_dm_err", dm_resp_err, 1'b1);
    chk32("to_dm_data", dm_resp.loadeddata, 32'hDEAD_BEEF);
    tick();
    settle();
    chk_state("to_late_ignored_state", ARB_IDLE);
    chk1("to_late_no_rvalid", dm_resp_valid | if_resp_valid, 1'b0);
    chk1("to_late_no_me_valid", me_req_valid, 1'b0);
    tick();
    me_resp_valid = 1'b0;
    me_resp       = '0;
    settle();
    chk_state("to_stray_idle_state", ARB_IDLE);
    chk32("to_stray_data_kept", dm_resp.loadeddata, 32'hDEAD_BEEF);

    // me_x request: memory skipped, error response next cycle
    dm_req       = mk_req(32'h40, 32'h0, me_x, mt_w);
    dm_req_valid = 1'b1;
    settle();
    chk1("mx_dm_ready", dm_req_ready, 1'b1);
    chk1("mx_me_valid_accept", me_req_valid, 1'b0);
    tick();
    dm_req_valid = 1'b0;
    settle();
    chk1("mx_dm_rvalid", dm_resp_valid, 1'b1);
    chk1("mx_dm_err", dm_resp_err, 1'b1);
    chk32("mx_dm_data", dm_resp.loadeddata, 32'hDEAD_BEEF);
    chk1("mx_me_valid_resp", me_req_valid, 1'b0);
    tick();
    settle();
    chk1("mx_me_valid_after", me_req_valid, 1'b0);
    chk1("mx_rvalid_drop", dm_resp_valid, 1'b0);

    // reset in ARB_WAIT abandons the transaction
    if_req       = mk_req(32'h500, 32'h0, me_rd, mt_w);
    if_req_valid = 1'b1;
    me_req_ready = 1'b1;
    tick();
    if_req_valid = 1'b0;
    tick();
    settle();
    chk_state("rw_in_wait", ARB_WAIT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_reset_outputs("rw_after_rst");
    me_resp_valid      = 1'b1;
    me_resp.loadeddata = 32'h5555_AAAA;
    tick();
    me_resp_valid = 1'b0;
    settle();
    chk1("rw_no_if_resp", if_resp_valid, 1'b0);
    chk1("rw_no_dm_resp", dm_resp_valid, 1'b0);
    chk_state("rw_idle", ARB_IDLE);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
